// File: rtl/d_sram_like_bridge.sv
// Data-port bridge: core SRAM-style access -> SRAM-like bus transaction.
// Ports: core side data_sram_*, longest_stall/d_stall; bus side data_*.
module d_sram_like_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_sram_en,
  input  logic [3:0]        data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,
  input  logic              longest_stall,
  output logic              d_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              fin;
  logic              wr_n;
  logic [1:0]        size_n;
  logic [ADDR_W-1:0] addr_n;

  // Transaction finishes in the cycle data_ok arrives while in DATA.
  assign fin = (state == DATA) && data_data_ok;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (data_sram_en) state_n = ADDR;
      ADDR: if (data_addr_ok) state_n = DATA;
      DATA: begin
        if (data_data_ok) begin
          state_n = longest_stall ? DONE : IDLE;
        end
      end
      DONE: if (!longest_stall) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Request fields for the access being launched.
  always_comb begin
    wr_n   = |data_sram_wen;
    size_n = 2'b10;
    addr_n = {data_sram_addr[ADDR_W-1:2], 2'b00};
    if (wr_n) begin
      addr_n = data_sram_addr;
      unique case (1'b1)
        data_sram_wen == 4'b1111:  size_n = 2'b10;
        data_sram_wen == 4'b0011,
        data_sram_wen == 4'b1100:  size_n = 2'b01;
        $onehot(data_sram_wen):    size_n = 2'b00;
        default:                   size_n = 2'b10;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && data_sram_en) begin
      wr_q    <= wr_n;
      size_q  <= size_n;
      addr_q  <= addr_n;
      wdata_q <= data_sram_wdata;
    end
  end

  // Only reads update the held result; writes leave it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (fin && !wr_q) begin
      rdata_q <= data_rdata;
    end
  end

  assign data_req   = (state == ADDR);
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

  assign data_sram_rdata = (fin && !wr_q) ? data_rdata : rdata_q;

  // Released in the data_ok cycle; gated by reset so it drops at once.
  assign d_stall = rst & data_sram_en & (state != DONE) & ~fin;

endmodule

// File: tb/tb_d_sram_like_bridge.sv
// Randomized bench for d_sram_like_bridge with a transaction-level model.
// Drives core and slave sides; checks bus fields, stalls and read data.
module tb_d_sram_like_bridge;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] crdata;
  logic        lstall;
  logic        dstall;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] baddr;
  logic [31:0] bwdata;
  logic        aok;
  logic        dok;
  logic [31:0] brdata;

  int checks;
  int errors;
  logic [31:0] last_read;

  d_sram_like_bridge #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (crdata),
    .longest_stall   (lstall),
    .d_stall         (dstall),
    .data_req        (req),
    .data_wr         (wr),
    .data_size       (size),
    .data_addr       (baddr),
    .data_wdata      (bwdata),
    .data_addr_ok    (aok),
    .data_data_ok    (dok),
    .data_rdata      (brdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Size rule from the byte-enable count and position.
  function automatic logic [1:0] exp_size(input logic [3:0] w);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += int'(w[i]);
    if (w == 4'b0000) return 2'b10;
    if (n == 1) return 2'b00;
    if (w == 4'b0011 || w == 4'b1100) return 2'b01;
    return 2'b10;
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    en     = 1'b0;
    wen    = 4'($urandom);
    addr   = $urandom;
    lstall = 1'($urandom);
    aok    = 1'b0;
    dok    = 1'($urandom);
    brdata = $urandom;
    #1;
    chk("idle_stall", dstall, 1'b0);
    chk("idle_req", req, 1'b0);
    chk("idle_rdata", crdata, last_read);
  endtask

  task automatic do_access(input logic [3:0]  w,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           input int          aw,
                           input int          dw,
                           input logic [31:0] rd,
                           input int          post);
    logic        ewr;
    logic [1:0]  esz;
    logic [31:0] ea;
    ewr = (w != 4'b0000);
    esz = exp_size(w);
    ea  = ewr ? a : (a & 32'hFFFF_FFFC);
    @(negedge clk);
    en     = 1'b1;
    wen    = w;
    addr   = a;
    wdata  = d;
    lstall = 1'b1;
    aok    = 1'b0;
    dok    = 1'($urandom);
    brdata = $urandom;
    #1;
    chk("c0_stall", dstall, 1'b1);
    chk("c0_req", req, 1'b0);
    for (int i = 0; i <= aw; i++) begin
      @(negedge clk);
      aok    = (i == aw);
      dok    = 1'($urandom);
      brdata = $urandom;
      #1;
      chk("a_req", req, 1'b1);
      chk("a_addr", baddr, ea);
      chk("a_wr", wr, ewr);
      chk("a_size", size, esz);
      chk("a_wdata", bwdata, d);
      chk("a_stall", dstall, 1'b1);
      chk("a_rdata", crdata, last_read);
    end
    for (int i = 0; i < dw; i++) begin
      @(negedge clk);
      aok    = 1'b0;
      dok    = 1'b0;
      brdata = $urandom;
      #1;
      chk("d_req", req, 1'b0);
      chk("d_stall", dstall, 1'b1);
    end
    @(negedge clk);
    aok    = 1'b0;
    dok    = 1'b1;
    brdata = rd;
    lstall = (post > 0);
    #1;
    chk("ok_stall", dstall, 1'b0);
    chk("ok_req", req, 1'b0);
    if (!ewr) begin
      last_read = rd;
    end
    chk("ok_rdata", crdata, ewr ? crdata : last_read);
    if (!ewr) chk("ok_rd_val", crdata, rd);
    for (int i = 0; i < post; i++) begin
      @(negedge clk);
      dok    = 1'b0;
      brdata = $urandom;
      lstall = (i < post - 1);
      #1;
      chk("hold_stall", dstall, 1'b0);
      chk("hold_req", req, 1'b0);
      chk("hold_rdata", crdata, last_read);
    end
  endtask

  task automatic reset_in_data();
    @(negedge clk);
    en     = 1'b1;
    wen    = 4'b0000;
    addr   = 32'h0000_1230;
    lstall = 1'b1;
    aok    = 1'b0;
    dok    = 1'b0;
    @(negedge clk);
    aok = 1'b1;
    @(negedge clk);
    aok = 1'b0;
    dok = 1'b0;
    #1;
    chk("r_pre_stall", dstall, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("r_req", req, 1'b0);
    chk("r_stall", dstall, 1'b0);
    chk("r_rdata", crdata, 32'h0);
    chk("r_size", size, 2'b00);
    chk("r_addr", baddr, 32'h0);
    @(negedge clk);
    dok    = 1'b1;
    brdata = 32'h5555_AAAA;
    #1;
    chk("r_dok_rdata", crdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    last_read = 32'h0;
    #1;
    chk("r_post_rdata", crdata, 32'h0);
    chk("r_post_req", req, 1'b0);
    idle_cycle();
  endtask

  initial begin
    logic [3:0] wtab [6];
    logic [3:0] w;
    checks    = 0;
    errors    = 0;
    last_read = 32'h0;
    wtab = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b1000, 4'b0101};
    rst    = 1'b0;
    en     = 1'b1;
    wen    = 4'b0000;
    addr   = 32'h0;
    wdata  = 32'h0;
    lstall = 1'b0;
    aok    = 1'b0;
    dok    = 1'b0;
    brdata = 32'h0;
    #3;
    chk("rst_stall", dstall, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_wr", wr, 1'b0);
    chk("rst_size", size, 2'b00);
    chk("rst_addr", baddr, 32'h0);
    chk("rst_wdata", bwdata, 32'h0);
    chk("rst_rdata", crdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    idle_cycle();

    do_access(4'b0000, 32'h1FC0_0006, 32'h0, 0, 0,
              32'hDEAD_BEEF, 0);
    idle_cycle();
    do_access(4'b0100, 32'h8000_0012, 32'h00AB_0000, 3, 1,
              32'h0, 0);
    idle_cycle();
    do_access(4'b0000, 32'h0000_0040, 32'h0, 1, 2,
              32'h1234_5678, 3);
    idle_cycle();
    do_access(4'b1100, 32'h0000_0102, 32'hBEEF_0000, 0, 0,
              32'h0, 1);
    do_access(4'b0110, 32'h0000_0201, 32'h00CC_DD00, 1, 0,
              32'h0, 0);
    idle_cycle();
    reset_in_data();
    do_access(4'b0000, 32'h0000_0100, 32'h0, 0, 1,
              32'hA1A1_A1A1, 0);
    do_access(4'b0000, 32'h0000_0207, 32'h0, 0, 0,
              32'hB2B2_B2B2, 0);
    idle_cycle();

    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 9) < 4) begin
        w = 4'b0000;
      end else if ($urandom_range(0, 1) == 0) begin
        w = wtab[$urandom_range(0, 5)];
      end else begin
        w = 4'($urandom_range(1, 15));
      end
      do_access(w, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
